// File: rtl/crossing_scheduler_pkg.sv
// Shared definitions for the crossing scheduler: FSM encoding, sequencer
// light-pattern decode values, requester/mode encodings and a sizing helper.
package crossing_scheduler_pkg;

  // 3-bit FSM encoding; codes 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_CROSS = 3'd2,
    ST_CLEAR = 3'd3,
    ST_GAP   = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  // Light patterns produced by the trafficlight sequencer.
  localparam logic [4:0] LS_ROAD_GREEN = 5'b01001;
  localparam logic [4:0] LS_SEQ_FIRST  = 5'b10010;
  localparam logic [4:0] LS_SEQ_LAST   = 5'b01110;

  // Crossing modes double as requester indices (0 = pedestrian, 1 = cyclist).
  localparam logic MODE_PED = 1'b0;
  localparam logic MODE_CYC = 1'b1;
  localparam int   NUM_REQ  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/crossing_req_latch.sv
// One requester's button latch: remembers a press until the scheduler
// starts serving it. Only a rising edge of the button creates a request,
// so a held button is a single request. A new press in the same cycle as
// the service clear keeps the request pending.
module crossing_req_latch (
  input  logic clock,
  input  logic reset,
  input  logic button,
  input  logic clear,
  output logic pending
);

  logic hist_q;
  logic pend_q, pend_d;
  logic rise;

  assign rise = button & ~hist_q;

  // Set beats clear so a press landing on the service edge is not lost.
  always_comb begin
    pend_d = rise | (pend_q & ~clear);
  end

  // Button history and pending bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      hist_q <= button;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/crossing_scheduler.sv
// Crossing request scheduler: latches pedestrian/cyclist requests, picks one
// round-robin, drives the sequencer start, follows the crossing through the
// sequencer's light pattern and enforces a road-green gap between crossings.
// A watchdog traps a sequencer that never starts or never finishes.
module crossing_scheduler
  import crossing_scheduler_pkg::*;
#(
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 8,
  parameter int SEQ_TIMEOUT   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ped_button,
  input  logic       cyc_button,
  input  logic [4:0] lightseq,
  output logic       start,
  output logic       crossing_mode,
  output logic       ped_wait,
  output logic       cyc_wait,
  output logic       busy,
  output logic       fault
);

  localparam int CNT_MAX = max3(GAP_CYCLES, START_TIMEOUT, SEQ_TIMEOUT);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Counter reload values: each phase ends when the counter is at 0, so a
  // phase of N cycles loads N-1 on entry.
  localparam logic [CNT_W-1:0] LD_ARM   = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_CROSS = CNT_W'(SEQ_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               last_q, last_d;
  logic               grant;

  logic [NUM_REQ-1:0] btn;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] clr;

  // Requester index equals its mode encoding.
  assign btn = {cyc_button, ped_button};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    crossing_req_latch u_latch (
      .clock   (clock),
      .reset   (reset),
      .button  (btn[i]),
      .clear   (clr[i]),
      .pending (pend[i])
    );
  end

  // Round-robin pick: a lone request wins, a tie goes to whoever was not
  // served last.
  always_comb begin
    if (pend[MODE_PED] && pend[MODE_CYC]) grant = ~last_q;
    else                                  grant = pend[MODE_CYC];
  end

  // Next state, shared counter and mode bookkeeping. Exit conditions are
  // checked before the counter so a late-but-valid pattern still advances.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    mode_d  = mode_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          state_d = ST_ARM;
          mode_d  = grant;
          last_d  = grant;
        end
      end
      ST_ARM: begin
        if (lightseq == LS_SEQ_FIRST) state_d = ST_CROSS;
        else if (cnt_q == '0)         state_d = ST_FAULT;
      end
      ST_CROSS: begin
        if (lightseq == LS_SEQ_LAST) state_d = ST_CLEAR;
        else if (cnt_q == '0)        state_d = ST_FAULT;
      end
      ST_CLEAR: begin
        if (lightseq == LS_ROAD_GREEN) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The one counter is reused by every timed phase, so reload on entry.
    if (state_d != state_q) begin
      case (state_d)
        ST_ARM:   cnt_d = LD_ARM;
        ST_CROSS: cnt_d = LD_CROSS;
        ST_GAP:   cnt_d = LD_GAP;
        default:  cnt_d = '0;
      endcase
    end
  end

  // The served request is retired as the sequencer confirms the crossing.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      clr[i] = (state_q == ST_ARM) && (state_d == ST_CROSS) && (mode_q == 1'(i));
    end
  end

  // State register; last_mode starts at cyclist so the first tie serves
  // the pedestrian.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_PED;
      last_q  <= MODE_CYC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
    end
  end

  assign start         = (state_q == ST_ARM);
  assign busy          = (state_q == ST_ARM) || (state_q == ST_CROSS) || (state_q == ST_CLEAR);
  assign fault         = (state_q == ST_FAULT);
  assign crossing_mode = mode_q;
  assign ped_wait      = pend[MODE_PED];
  assign cyc_wait      = pend[MODE_CYC];

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed bench for crossing_scheduler. The sequencer's light pattern is
// driven by hand with the timing a real trafficlight would produce.
// Observed vector: {start, busy, fault, ped_wait, cyc_wait, crossing_mode}.
module tb_crossing_scheduler;
  import crossing_scheduler_pkg::*;

  localparam logic [4:0] LS_MID  = 5'b10100;
  localparam logic [4:0] LS_POST = 5'b00110;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ped_button = 1'b0;
  logic       cyc_button = 1'b0;
  logic [4:0] lightseq = LS_ROAD_GREEN;
  logic       start, crossing_mode, ped_wait, cyc_wait, busy, fault;
  logic [5:0] obs;
  int         total = 0;
  int         bad = 0;

  assign obs = {start, busy, fault, ped_wait, cyc_wait, crossing_mode};

  crossing_scheduler #(.GAP_CYCLES(16), .START_TIMEOUT(8), .SEQ_TIMEOUT(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .ped_button    (ped_button),
    .cyc_button    (cyc_button),
    .lightseq      (lightseq),
    .start         (start),
    .crossing_mode (crossing_mode),
    .ped_wait      (ped_wait),
    .cyc_wait      (cyc_wait),
    .busy          (busy),
    .fault         (fault)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    ped_button = 1'b0;
    cyc_button = 1'b0;
    lightseq = LS_ROAD_GREEN;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Button pulse seen at the next edge.
  task automatic press(input logic p, input logic c);
    ped_button = p;
    cyc_button = c;
    tick();
    ped_button = 1'b0;
    cyc_button = 1'b0;
  endtask

  // From CROSS (pattern already at first phase) through CLEAR into GAP.
  task automatic finish_crossing;
    lightseq = LS_MID;
    repeat (3) tick();
    lightseq = LS_SEQ_LAST;
    tick();
    lightseq = LS_POST;
    tick();
    lightseq = LS_ROAD_GREEN;
    tick();
  endtask

  task automatic test_reset;
    int seen;
    do_reset(2);
    total++; if (obs !== 6'b000000) begin bad++; $display("FAIL reset_outputs: got %b want %b", obs, 6'b000000); end
    seen = 0;
    repeat (50) begin tick(); if (start) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL idle_no_start: got %0d start cycles want 0", seen); end
  endtask

  task automatic test_ped_crossing;
    press(1'b1, 1'b0);
    total++; if (obs !== 6'b000100) begin bad++; $display("FAIL ped_edge_k: got %b want %b", obs, 6'b000100); end
    tick();
    total++; if (obs !== 6'b110100) begin bad++; $display("FAIL ped_arm_k1: got %b want %b", obs, 6'b110100); end
    tick();
    lightseq = LS_SEQ_FIRST;
    tick();
    total++; if (obs !== 6'b010000) begin bad++; $display("FAIL ped_cross_k3: got %b want %b", obs, 6'b010000); end
    finish_crossing();
    total++; if (obs !== 6'b000000) begin bad++; $display("FAIL ped_gap: got %b want %b", obs, 6'b000000); end
    repeat (16) tick();
  endtask

  task automatic test_tie;
    int n;
    do_reset(2);
    press(1'b1, 1'b1);
    total++; if (obs !== 6'b000110) begin bad++; $display("FAIL tie_pending: got %b want %b", obs, 6'b000110); end
    tick();
    total++; if (obs !== 6'b110110) begin bad++; $display("FAIL tie_ped_first: got %b want %b", obs, 6'b110110); end
    tick();
    lightseq = LS_SEQ_FIRST;
    tick();
    total++; if (obs !== 6'b010010) begin bad++; $display("FAIL tie_ped_cross: got %b want %b", obs, 6'b010010); end
    finish_crossing();
    n = 0;
    for (int i = 0; i < 40 && !start; i++) begin tick(); n++; end
    total++; if (n !== 17) begin bad++; $display("FAIL tie_gap_len: got %0d cycles want 17", n); end
    total++; if (obs !== 6'b110011) begin bad++; $display("FAIL tie_cyc_arm: got %b want %b", obs, 6'b110011); end
    tick();
    lightseq = LS_SEQ_FIRST;
    tick();
    total++; if (obs !== 6'b010001) begin bad++; $display("FAIL tie_cyc_cross: got %b want %b", obs, 6'b010001); end
    finish_crossing();
    repeat (16) tick();
    // Last served was cyclist, so the next tie goes to the pedestrian.
    press(1'b1, 1'b1);
    tick();
    total++; if (obs !== 6'b110110) begin bad++; $display("FAIL tie2_ped: got %b want %b", obs, 6'b110110); end
    tick();
    lightseq = LS_SEQ_FIRST;
    tick();
    finish_crossing();
    repeat (17) tick();
    total++; if (obs !== 6'b110011) begin bad++; $display("FAIL tie2_cyc: got %b want %b", obs, 6'b110011); end
  endtask

  task automatic test_held;
    int seen, n;
    do_reset(2);
    ped_button = 1'b1;
    tick();
    tick();
    tick();
    lightseq = LS_SEQ_FIRST;
    tick();
    total++; if (obs !== 6'b010000) begin bad++; $display("FAIL held_cross: got %b want %b", obs, 6'b010000); end
    finish_crossing();
    seen = 0;
    repeat (174) begin tick(); if (start || ped_wait) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL held_single: got %0d extra request cycles want 0", seen); end
    ped_button = 1'b0;
    tick();
    // New crossing; a second press lands while it is in CROSS.
    press(1'b1, 1'b0);
    tick();
    tick();
    lightseq = LS_SEQ_FIRST;
    tick();
    lightseq = LS_MID;
    press(1'b1, 1'b0);
    total++; if (obs !== 6'b010100) begin bad++; $display("FAIL press_in_cross: got %b want %b", obs, 6'b010100); end
    finish_crossing();
    n = 0;
    for (int i = 0; i < 40 && !start; i++) begin tick(); n++; end
    total++; if (n !== 17) begin bad++; $display("FAIL second_after_gap: got %0d cycles want 17", n); end
  endtask

  task automatic test_start_timeout;
    int n, seen;
    do_reset(2);
    press(1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 30 && !fault; i++) begin tick(); if (start) n++; end
    total++; if (n !== 8) begin bad++; $display("FAIL start_len: got %0d cycles want 8", n); end
    total++; if (obs !== 6'b001100) begin bad++; $display("FAIL fault_state: got %b want %b", obs, 6'b001100); end
    press(1'b0, 1'b1);
    total++; if (obs !== 6'b001110) begin bad++; $display("FAIL fault_press: got %b want %b", obs, 6'b001110); end
    seen = 0;
    repeat (20) begin tick(); if (start || !fault) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL fault_sticky: got %0d bad cycles want 0", seen); end
  endtask

  task automatic test_exit_priority;
    do_reset(2);
    press(1'b1, 1'b0);
    tick();
    repeat (7) tick();
    total++; if (obs !== 6'b110100) begin bad++; $display("FAIL arm_last_cycle: got %b want %b", obs, 6'b110100); end
    lightseq = LS_SEQ_FIRST;
    tick();
    total++; if (obs !== 6'b010000) begin bad++; $display("FAIL exit_beats_timeout: got %b want %b", obs, 6'b010000); end
  endtask

  task automatic test_seq_timeout;
    do_reset(2);
    press(1'b1, 1'b0);
    tick();
    lightseq = LS_SEQ_FIRST;
    tick();
    lightseq = LS_MID;
    repeat (15) tick();
    total++; if (obs !== 6'b010000) begin bad++; $display("FAIL cross_before_timeout: got %b want %b", obs, 6'b010000); end
    tick();
    total++; if (obs !== 6'b001000) begin bad++; $display("FAIL cross_timeout: got %b want %b", obs, 6'b001000); end
  endtask

  task automatic test_reset_mid;
    do_reset(2);
    press(1'b0, 1'b1);
    tick();
    lightseq = LS_SEQ_FIRST;
    tick();
    total++; if (obs !== 6'b010001) begin bad++; $display("FAIL cyc_cross: got %b want %b", obs, 6'b010001); end
    lightseq = LS_MID;
    press(1'b1, 1'b0);
    do_reset(1);
    total++; if (obs !== 6'b000000) begin bad++; $display("FAIL reset_mid: got %b want %b", obs, 6'b000000); end
    press(1'b1, 1'b0);
    tick();
    total++; if (obs !== 6'b110100) begin bad++; $display("FAIL after_reset_arm: got %b want %b", obs, 6'b110100); end
    tick();
    lightseq = LS_SEQ_FIRST;
    tick();
    total++; if (obs !== 6'b010000) begin bad++; $display("FAIL after_reset_cross: got %b want %b", obs, 6'b010000); end
  endtask

  initial begin
    test_reset();
    test_ped_crossing();
    test_tie();
    test_held();
    test_start_timeout();
    test_exit_priority();
    test_seq_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
